uncache_store_axi_bridge: RTL

//  Consumes uncached entries at the head of the store buffer and issues each
//  one as a single-beat AXI write (AW/W/B). Sits directly downstream of the

---
 rtl/uncache_store_axi_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uncache_store_axi_bridge.sv
// uncache_store_axi_bridge: drains uncached store-buffer head entries as
// single-beat AXI writes (AW/W/B), one write outstanding at a time.
// Optional build macro UCS_TIMEOUT_EN adds a watchdog that abandons a write
// stuck in SEND or RESP for TIMEOUT_CYC cycles.
module uncache_store_axi_bridge #(
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [31:0]     sb_addr,
    input  logic [31:0]     sb_data,
    input  logic [3:0]      sb_rwen,
    input  logic            sb_uncache,
    output logic            ucs_busy,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic            bvalid,
    input  logic [1:0]      bresp,
    output logic            bready,
    output logic            ucs_err
);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } req_t;

    state_t state;
    req_t   req;

    // Transfer size from the byte-enable pattern; irregular masks go out as
    // a full word and rely on wstrb to select the bytes.
    function automatic logic [2:0] size_of(input logic [3:0] rwen);
        case (rwen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 3'd0;
            4'b0011, 4'b1100:                   size_of = 3'd1;
            default:                            size_of = 3'd2;
        endcase
    endfunction

    // Fixed single-beat INCR burst, ID 0
    assign awid    = '0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;
    assign awaddr  = req.addr;
    assign awsize  = req.size;
    assign wdata   = req.data;
    assign wstrb   = req.strb;

    // A channel is finished once its valid has dropped or its handshake is
    // completing this cycle.
    logic aw_ok, w_ok, send_done, tmo_hit;
    assign aw_ok     = !awvalid || awready;
    assign w_ok      = !wvalid  || wready;
    assign send_done = aw_ok && w_ok;

`ifdef UCS_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;

    // Watchdog counter restarts on entry to SEND and to RESP
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            tmo_cnt <= '0;
        else if (state == IDLE || (state == SEND && send_done))
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    // Main FSM: accept, run AW and W independently, wait for B
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            req      <= '0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            ucs_busy <= 1'b0;
            ucs_err  <= 1'b0;
        end else begin
            ucs_err <= 1'b0;
            case (state)
                IDLE: begin
                    // zero-mask uncached entries are popped by the buffer and dropped here
                    if (sb_uncache && sb_rwen != 4'b0000) begin
                        req      <= '{addr: sb_addr, data: sb_data, strb: sb_rwen,
                                      size: size_of(sb_rwen)};
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        ucs_busy <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (send_done) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        ucs_busy <= 1'b0;
                        ucs_err  <= (bresp != 2'b00);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // watchdog abandons the write; later assignments take priority
            if (tmo_hit) begin
                awvalid  <= 1'b0;
                wvalid   <= 1'b0;
                bready   <= 1'b0;
                ucs_busy <= 1'b0;
                ucs_err  <= 1'b1;
                state    <= IDLE;
            end
        end
    end

endmodule
